// File: rtl/keypad_scan_encoder_if.sv
// Keypad-side bundle: matrix row/column pins plus the strobe/func outputs for calculator_dec.
// Pure wiring; no storage or latency of its own.
// No handshake: the strobes are fire-and-forget pulses; column inputs are sampled, never stalled.
interface keypad_scan_encoder_if;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic       zero;
  logic       one;
  logic       two;
  logic       three;
  logic       four;
  logic       five;
  logic       six;
  logic       seven;
  logic       eight;
  logic       nine;
  logic [2:0] func;
  logic       get_res;

  // Encoder side: samples the columns, drives rows and the decoded outputs.
  modport master (
    input  col_n,
    output row_n, zero, one, two, three, four, five, six, seven, eight, nine, func, get_res
  );

  // Board/consumer side: the matrix drives columns, calculator_dec consumes the outputs.
  modport slave (
    output col_n,
    input  row_n, zero, one, two, three, four, five, six, seven, eight, nine, func, get_res
  );
endinterface

// File: rtl/keypad_scan_encoder.sv
// Scans a 4x4 active-low key matrix, debounces a single key and emits one strobe per press.
// Latency: 2-cycle column sync + row sample point + DEBOUNCE cycles to the first strobe cycle.
// No backpressure: strobes are fixed PULSE_LEN pulses; new presses are ignored until full release.
module keypad_scan_encoder #(
  parameter int SCAN_DIV  = 16,
  parameter int DEBOUNCE  = 8,
  parameter int PULSE_LEN = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  keypad_scan_encoder_if.master kp
);

  localparam int DIV_W = $clog2(SCAN_DIV + 1);
  localparam int DEB_W = $clog2(DEBOUNCE + 1);
  localparam int PUL_W = $clog2(PULSE_LEN + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE - 1);
  localparam logic [PUL_W-1:0] PUL_LAST = PUL_W'(PULSE_LEN - 1);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_EMIT,
    ST_WAIT_RELEASE
  } state_t;

  state_t           state;
  logic [3:0]       col_meta;
  logic [3:0]       csync;
  logic [1:0]       row_idx;
  logic [3:0]       row_n_q;
  logic [DIV_W-1:0] div_cnt;
  logic [DEB_W-1:0] deb_cnt;
  logic [PUL_W-1:0] pulse_cnt;
  logic [1:0]       key_row;
  logic [1:0]       key_col;
  logic [9:0]       digit_q;
  logic             get_res_q;
  logic [2:0]       func_q;

  logic [3:0]       pressed;
  logic             single;
  logic [1:0]       hit_col;
  logic [3:0]       key_pat;
  logic [9:0]       dec_digit;
  logic             dec_hash;
  logic             dec_func_ld;
  logic [2:0]       dec_func;

  // One-cold row drive for a given row index.
  function automatic logic [3:0] row_drive(input logic [1:0] idx);
    logic [3:0] r;
    r      = 4'b1111;
    r[idx] = 1'b0;
    return r;
  endfunction

  assign pressed = ~csync;
  assign single  = (pressed != 4'd0) && ((pressed & (pressed - 4'd1)) == 4'd0);
  assign key_pat = row_drive(key_col);

  // Column index of the single pressed column (only meaningful when single is set).
  always_comb begin
    hit_col = 2'd0;
    case (pressed)
      4'b0010: hit_col = 2'd1;
      4'b0100: hit_col = 2'd2;
      4'b1000: hit_col = 2'd3;
      default: hit_col = 2'd0;
    endcase
  end

  // Key map: latched (row,col) to digit strobe, '#' request or func load.
  always_comb begin
    dec_digit   = 10'd0;
    dec_hash    = 1'b0;
    dec_func_ld = 1'b0;
    dec_func    = 3'b000;
    case ({key_row, key_col})
      4'h0: dec_digit[1] = 1'b1;
      4'h1: dec_digit[2] = 1'b1;
      4'h2: dec_digit[3] = 1'b1;
      4'h3: begin dec_func_ld = 1'b1; dec_func = 3'b001; end
      4'h4: dec_digit[4] = 1'b1;
      4'h5: dec_digit[5] = 1'b1;
      4'h6: dec_digit[6] = 1'b1;
      4'h7: begin dec_func_ld = 1'b1; dec_func = 3'b010; end
      4'h8: dec_digit[7] = 1'b1;
      4'h9: dec_digit[8] = 1'b1;
      4'hA: dec_digit[9] = 1'b1;
      4'hB: begin dec_func_ld = 1'b1; dec_func = 3'b011; end
      4'hC: begin dec_func_ld = 1'b1; dec_func = 3'b000; end
      4'hD: dec_digit[0] = 1'b1;
      4'hE: dec_hash = 1'b1;
      default: begin dec_func_ld = 1'b1; dec_func = 3'b100; end
    endcase
  end

  // Two-flop synchronizer for the asynchronous column inputs; idle level is all-high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta <= 4'b1111;
      csync    <= 4'b1111;
    end else begin
      col_meta <= kp.col_n;
      csync    <= col_meta;
    end
  end

  // Scan / debounce / emit / release FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_SCAN;
      row_idx   <= 2'd0;
      row_n_q   <= 4'b1110;
      div_cnt   <= '0;
      deb_cnt   <= '0;
      pulse_cnt <= '0;
      key_row   <= 2'd0;
      key_col   <= 2'd0;
      digit_q   <= 10'd0;
      get_res_q <= 1'b0;
      func_q    <= 3'b000;
    end else begin
      case (state)
        ST_SCAN: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (single) begin
              // Hold this row while the candidate key is debounced.
              key_row <= row_idx;
              key_col <= hit_col;
              deb_cnt <= '0;
              state   <= ST_DEBOUNCE;
            end else begin
              row_idx <= row_idx + 2'd1;
              row_n_q <= row_drive(row_idx + 2'd1);
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        ST_DEBOUNCE: begin
          if (csync == key_pat) begin
            if (deb_cnt == DEB_LAST) begin
              deb_cnt   <= '0;
              pulse_cnt <= '0;
              digit_q   <= dec_digit;
              get_res_q <= dec_hash;
              if (dec_func_ld) begin
                func_q <= dec_func;
              end
              state     <= ST_EMIT;
            end else begin
              deb_cnt <= deb_cnt + DEB_W'(1);
            end
          end else begin
            // Bounce: give up on this key and carry on from the next row.
            deb_cnt <= '0;
            div_cnt <= '0;
            row_idx <= row_idx + 2'd1;
            row_n_q <= row_drive(row_idx + 2'd1);
            state   <= ST_SCAN;
          end
        end
        ST_EMIT: begin
          if (pulse_cnt == PUL_LAST) begin
            digit_q   <= 10'd0;
            get_res_q <= 1'b0;
            deb_cnt   <= '0;
            state     <= ST_WAIT_RELEASE;
          end else begin
            pulse_cnt <= pulse_cnt + PUL_W'(1);
          end
        end
        ST_WAIT_RELEASE: begin
          if (csync == 4'b1111) begin
            if (deb_cnt == DEB_LAST) begin
              deb_cnt <= '0;
              div_cnt <= '0;
              row_idx <= 2'd0;
              row_n_q <= 4'b1110;
              state   <= ST_SCAN;
            end else begin
              deb_cnt <= deb_cnt + DEB_W'(1);
            end
          end else begin
            deb_cnt <= '0;
          end
        end
        default: state <= ST_SCAN;
      endcase
    end
  end

  assign kp.row_n   = row_n_q;
  assign kp.zero    = digit_q[0];
  assign kp.one     = digit_q[1];
  assign kp.two     = digit_q[2];
  assign kp.three   = digit_q[3];
  assign kp.four    = digit_q[4];
  assign kp.five    = digit_q[5];
  assign kp.six     = digit_q[6];
  assign kp.seven   = digit_q[7];
  assign kp.eight   = digit_q[8];
  assign kp.nine    = digit_q[9];
  assign kp.func    = func_q;
  assign kp.get_res = get_res_q;

endmodule

// File: doc/keypad_scan_encoder.md
Name: keypad_scan_encoder

Overview:
- Front end for calculator_dec: scans a 4x4 active-low key matrix, debounces presses and converts them into the digit strobes (zero..nine), operation code (func) and get_res request that calculator_dec consumes.
- Generates one clean, fixed-width strobe per physical press, with no auto-repeat.
- Instantiated at board top, between the keypad pins and calculator_dec.

Parameters:
- SCAN_DIV, 16, clock cycles each row is driven before moving to the next row.
- DEBOUNCE, 8, consecutive stable column samples required to accept a press or a release.
- PULSE_LEN, 5, width in clock cycles of each digit or get_res strobe.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- col_n  in  4  matrix columns, active low. Asynchronous input; passes through a 2-FF synchronizer inside the block.
- row_n  out  4  matrix row drive, one-cold. Bit r low means row r is driven.
- zero, one, two, three, four, five, six, seven, eight, nine  out  1 each  digit strobes, active high.
- func  out  3  operation code, registered and held.
- get_res  out  1  result request strobe, active high.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low: rst_n low forces the state immediately; release is synchronous to clk.
- Reset values:
  - row_n=4'b1110.
  - All digit strobes and get_res = 0.
  - func=3'b000.
  - FSM in SCAN; all counters 0; synchronizer flops 4'b1111.
- Key map (row,col):
  - Row 0: 1 2 3 A.
  - Row 1: 4 5 6 B.
  - Row 2: 7 8 9 C.
  - Row 3: * 0 # D.
  - Column c corresponds to col_n[c].
- Sampling: csync is col_n after the 2-FF synchronizer. A column counts as pressed when its csync bit is 0.
- FSM states:
  - SCAN:
    - row_n rotates 1110 -> 1101 -> 1011 -> 0111 -> 1110, changing every SCAN_DIV cycles.
    - csync is evaluated on the last cycle of each row period.
    - Exactly one column pressed: latch (row,col), hold the current row, go to DEBOUNCE.
    - Zero columns pressed, or more than one: advance the row.
  - DEBOUNCE:
    - Each cycle, compare csync with the latched pattern.
    - Match: increment the counter. Mismatch: clear the counter, go to SCAN and resume rotation from the next row.
    - Counter reaches DEBOUNCE: go to EMIT.
  - EMIT:
    - Lasts exactly PULSE_LEN cycles.
    - Digit key: the matching digit strobe is high for PULSE_LEN cycles; all other strobes stay 0.
    - '#': get_res is high for PULSE_LEN cycles.
    - A/B/C/D: func is loaded with 001/010/011/100 respectively on the first EMIT cycle; no strobe is produced.
    - '*': func is loaded with 000; no strobe is produced.
    - func holds its value until the next operation key, '*', or reset.
    - After PULSE_LEN cycles, go to WAIT_RELEASE.
  - WAIT_RELEASE:
    - Row stays held.
    - Requires csync=4'b1111 for DEBOUNCE consecutive cycles; any low column clears the counter.
    - Then go to SCAN with row_n=1110.
    - A key held indefinitely produces exactly one event.
- Strobe rules:
  - At most one strobe output is high in any cycle.
  - Strobes are registered outputs.
- Latency: from col_n becoming stable on the currently driven row's sample point, the first strobe cycle follows within 2 + 1 + DEBOUNCE cycles.
- Boundary conditions:
  - A second key pressed during EMIT or WAIT_RELEASE is ignored until a full release is seen.
  - Multi-key on one row is ignored.
  - Keys pressed on two different rows: the first row scanned wins.
  - rst_n asserted mid-EMIT: strobe drops to 0 immediately and func returns to 000.
  - Row counter and debounce counter wrap only as described above; no counter saturates silently.

Test Plan:
1. Hold rst_n=0 for 3 cycles, with col_n=1111 -> row_n=1110, all strobes 0, func=000. Release reset -> row_n steps through 1101, 1011, 0111, 1110 every 16 cycles.
2. Bench matrix model presses '1' (row0, col0) for 300 cycles, then releases -> `one` high for exactly 5 consecutive cycles, once; no other strobe asserts and there is no repeat while held. After release, scanning resumes from row 0.
3. Press and release '1', '3', '0', '1' in sequence (each held 200 cycles, gaps 100 cycles) -> strobes one, three, zero, one, in that order, each 5 cycles wide.
4. Press A -> func=001 and stays 001 after release; press C -> 011; press '*' -> 000; press D -> 100; press '#' -> get_res high for 5 cycles, func still 100.
5. '5' toggled every 3 cycles for 40 cycles, then released -> no `five` strobe. Keys '1' and '2' held together for 200 cycles -> no strobes.
6. Press '7'; assert rst_n=0 during the 2nd cycle of the `seven` strobe -> `seven` falls immediately and func=000. After reset release with '7' still held -> one fresh `seven` strobe, 5 cycles wide.
